sdf_input_feeder: RTL and testbench
===================================

# sdf_input_feeder

Streams Q16.16 fixed-point samples produced by the input-conversion stage into the first butterfly stage of the radix-2 single-path delay-feedback (R2SDF) FFT pipeline. It frames the sample stream into LENGTH-point frames, tags frame boundaries, and zero-pads partial frames on request. It presents each sample as a complex value with a zero imaginary part, and applies valid/ready backpressure through a single output register. Optional input pre-scaling guards the butterflies against growth overflow.

## Interface
- LENGTH, 8, FFT points per frame; power of two, at least 2.
- WIDTH, 32, sample width; Q(WIDTH-FRAC).FRAC two's complement.
- FRAC, 16, fractional bits.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset; one clock, asynchronous, active-low.
- in_valid  in  1  in_data holds a sample.
- in_ready  out  1  block accepts a sample this cycle.
- in_data  in  WIDTH  converted sample (fpt).
- flush  in  1  single-cycle pulse: zero-pad the current partial frame.
- out_valid  out  1  output sample valid.
- out_ready  in  1  downstream accepts the output sample.
- out_re  out  WIDTH  real part.
- out_im  out  WIDTH  imaginary part; always 0.
- out_first  out  1  sample index 0 of the frame.
- out_last  out  1  sample index LENGTH-1 of the frame.
- frame_cnt  out  16  number of completed frames emitted; wraps at 2^16.

## Operation
- Input accept: in_valid && in_ready. Output transfer: out_valid && out_ready.
- in_ready = (!out_valid || out_ready) && state != PAD. The input side is combinational from registered state and out_ready.
- The block has three states:
  - IDLE: at a frame boundary (sample_cnt == 0).
  - FILL: mid-frame.
  - PAD: emitting zeros.
- sample_cnt is a $clog2(LENGTH)-bit counter. It advances on every sample loaded into the output register, whether real or padded.
- IDLE -> FILL on an accept when LENGTH > 1.
- FILL -> IDLE on the accept that loads index LENGTH-1.
- FILL -> PAD on flush when no accept happens that cycle.
- Flush and accept in the same cycle while in FILL:
  - The sample is taken first.
  - If that sample was index LENGTH-1, the next state is IDLE and no padding occurs.
  - Otherwise the next state is PAD.
- PAD loads zeros whenever the output register is free (!out_valid || out_ready). PAD -> IDLE after the zero at index LENGTH-1 is loaded.
- flush in IDLE is ignored. flush in PAD is ignored.
- Output register fields:
  - out_first = (index == 0).
  - out_last = (index == LENGTH-1).
  - out_re = data, scaled or padded.
- frame_cnt increments on transfer of a sample with out_last = 1.
- Arithmetic: no width change, WIDTH in and out. Zero padding = all bits 0.

## Timing
- Latency: 1 cycle. A sample accepted at edge N is out_valid after edge N.
- Throughput: 1 sample/cycle while out_ready = 1.
- Stall: when out_valid && !out_ready, all output fields hold stable and in_ready = 0.
- Reset values:
  - out_valid = 0, out_re = 0, out_im = 0, out_first = 0, out_last = 0.
  - frame_cnt = 0, state = IDLE, sample_cnt = 0.
  - in_ready = 1 after reset is released.
- Reset mid-frame: the partial frame is discarded with no padding. The next accepted sample is index 0.
- frame_cnt wraps from 0xFFFF to 0 without a flag.

## Configuration
- FEEDER_SCALE_EN defined: out_re = in_data >>> $clog2(LENGTH). This is an arithmetic shift with truncation toward negative infinity. Full-scale inputs cannot overflow across log2(LENGTH) butterfly stages.
- FEEDER_SCALE_EN undefined: out_re = in_data unchanged.
- Padded zeros are unaffected by the macro.

## Structure
- Shared package fft_pkg holds:
  - typedef fpt: logic signed [WIDTH-1:0].
  - FPT_W = 32 and FPT_FRAC = 16.
  - The state enum {IDLE, FILL, PAD}.
- Sub-module fpt_scale: a combinational arithmetic right shift by a parameter SHIFT. It is instantiated only under FEEDER_SCALE_EN.

## Test plan
- Back-to-back frame, LENGTH=8, scale off:
  - Stimulus: in_data = k·0x0001_0000 for k = 0..7 on consecutive cycles, out_ready = 1.
  - Response: out_re matches one cycle later; out_first on k=0, out_last on k=7; out_im = 0; frame_cnt = 1.
- Backpressure:
  - Stimulus: out_ready = 0 for 3 cycles with sample 0x0002_0000 in the output register.
  - Response: in_ready = 0 and out_re holds 0x0002_0000 for all 3 cycles; no sample lost or duplicated after release.
- Flush:
  - Stimulus: 3 samples (0x0001_0000 ×3), then a flush pulse.
  - Response: 3 data beats, then 5 zero beats with out_last on the 8th; in_ready = 0 during PAD; frame_cnt = 1.
- Flush coincident with index 7 accept:
  - Response: no padding; next frame starts at index 0.
- Reset mid-frame:
  - Stimulus: rst_n low after 4 samples.
  - Response: all outputs return to their reset values; the next sample carries out_first = 1.
- FEEDER_SCALE_EN, LENGTH=8:
  - Stimulus: in_data = 0x0008_0000, then 0xFFF8_0000.
  - Response: out_re = 0x0001_0000, then 0xFFFF_0000.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared fixed-point types and feeder state encoding for the R2SDF FFT pipeline.
package fft_pkg;

    localparam int FPT_W    = 32;
    localparam int FPT_FRAC = 16;

    typedef logic signed [FPT_W-1:0] fpt;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        PAD
    } feeder_state_e;

endpackage

// File: rtl/fpt_scale.sv
// Combinational arithmetic right shift of a two's-complement fixed-point sample.
module fpt_scale
    import fft_pkg::*;
#(
    parameter int WIDTH = FPT_W,
    parameter int SHIFT = 0
) (
    input  logic signed [WIDTH-1:0] in_data,
    output logic signed [WIDTH-1:0] out_data
);

    assign out_data = in_data >>> SHIFT;

endmodule

// File: rtl/sdf_input_feeder.sv
// Frames converted samples into LENGTH-point complex frames for the first R2SDF stage.
// Define FEEDER_SCALE_EN to pre-scale real samples by >>> $clog2(LENGTH).
module sdf_input_feeder
    import fft_pkg::*;
#(
    parameter int LENGTH = 8,
    parameter int WIDTH  = FPT_W,
    parameter int FRAC   = FPT_FRAC
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_re,
    output logic [WIDTH-1:0] out_im,
    output logic             out_first,
    output logic             out_last,
    output logic [15:0]      frame_cnt
);

    localparam int            CW       = $clog2(LENGTH);
    localparam logic [CW-1:0] LAST_IDX = CW'(LENGTH - 1);

    if (LENGTH < 2 || (LENGTH & (LENGTH - 1)) != 0 || FRAC >= WIDTH) begin : g_bad_cfg
        $error("sdf_input_feeder: invalid LENGTH/WIDTH/FRAC configuration");
    end

    feeder_state_e     state, state_nxt;
    logic [CW-1:0]     sample_cnt;
    logic              reg_free, accept, pad_load, load, last_idx;
    logic [WIDTH-1:0]  scaled;

`ifdef FEEDER_SCALE_EN
    fpt_scale #(
        .WIDTH (WIDTH),
        .SHIFT (CW)
    ) u_scale (
        .in_data  (in_data),
        .out_data (scaled)
    );
`else
    assign scaled = in_data;
`endif

    assign reg_free = !out_valid || out_ready;
    assign in_ready = reg_free && (state != PAD);
    assign accept   = in_valid && in_ready;
    assign pad_load = (state == PAD) && reg_free;
    assign load     = accept || pad_load;
    assign last_idx = (sample_cnt == LAST_IDX);
    assign out_im   = '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // A coincident accept wins over flush; padding starts only if the frame is still open.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (accept) state_nxt = FILL;
            end
            FILL: begin
                if (accept && last_idx) state_nxt = IDLE;
                else if (flush)         state_nxt = PAD;
            end
            PAD: begin
                if (pad_load && last_idx) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sample_cnt <= '0;
            out_valid  <= 1'b0;
            out_re     <= '0;
            out_first  <= 1'b0;
            out_last   <= 1'b0;
        end else if (load) begin
            sample_cnt <= sample_cnt + CW'(1);
            out_valid  <= 1'b1;
            out_re     <= accept ? scaled : '0;
            out_first  <= (sample_cnt == '0);
            out_last   <= last_idx;
        end else if (out_ready) begin
            out_valid  <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt <= '0;
        end else if (out_valid && out_ready && out_last) begin
            frame_cnt <= frame_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_sdf_input_feeder.sv
// Directed self-checking bench for sdf_input_feeder (LENGTH=8); honours FEEDER_SCALE_EN.
module tb_sdf_input_feeder;

    localparam int LENGTH = 8;
    localparam int WIDTH  = 32;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_re;
    logic [WIDTH-1:0] out_im;
    logic             out_first;
    logic             out_last;
    logic [15:0]      frame_cnt;

    int errors = 0;
    int checks = 0;

    sdf_input_feeder #(
        .LENGTH (LENGTH),
        .WIDTH  (WIDTH),
        .FRAC   (16)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_re    (out_re),
        .out_im    (out_im),
        .out_first (out_first),
        .out_last  (out_last),
        .frame_cnt (frame_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [WIDTH-1:0] exp_re(input logic [WIDTH-1:0] d);
`ifdef FEEDER_SCALE_EN
        return {{3{d[WIDTH-1]}}, d[WIDTH-1:3]};
`else
        return d;
`endif
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv)
        else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_beat(input string tag, input logic [WIDTH-1:0] re,
                            input logic first, input logic last);
        chk({tag, ".valid"}, out_valid, 1'b1);
        chk({tag, ".re"},    out_re,    re);
        chk({tag, ".im"},    out_im,    32'h0);
        chk({tag, ".first"}, out_first, first);
        chk({tag, ".last"},  out_last,  last);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        flush     = 1'b0;
        out_ready = 1'b0;
        #12;
        chk("rst.valid", out_valid, 1'b0);
        chk("rst.re",    out_re,    32'h0);
        chk("rst.im",    out_im,    32'h0);
        chk("rst.first", out_first, 1'b0);
        chk("rst.last",  out_last,  1'b0);
        chk("rst.fcnt",  frame_cnt, 16'h0);
        rst_n = 1'b1;
        #1;
        chk("rst.in_ready", in_ready, 1'b1);
        tick();

        // Back-to-back frame
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            in_valid = 1'b1;
            in_data  = WIDTH'(k) << 16;
            tick();
            chk_beat("b2b", exp_re(WIDTH'(k) << 16), k == 0, k == 7);
        end
        in_valid = 1'b0;
        tick();
        chk("b2b.idle_valid", out_valid, 1'b0);
        chk("b2b.fcnt",       frame_cnt, 16'd1);

        // Backpressure with 0x0002_0000 held in the output register
        in_valid = 1'b1;
        in_data  = 32'h0001_0000;
        tick();
        chk_beat("bp0", exp_re(32'h0001_0000), 1'b1, 1'b0);
        in_data = 32'h0002_0000;
        tick();
        chk_beat("bp1", exp_re(32'h0002_0000), 1'b0, 1'b0);
        in_data   = 32'h0003_0000;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp.stall_in_ready", in_ready, 1'b0);
            tick();
            chk_beat("bp.stall", exp_re(32'h0002_0000), 1'b0, 1'b0);
        end
        out_ready = 1'b1;
        for (int k = 2; k < 8; k++) begin
            in_data = WIDTH'(k + 1) << 16;
            tick();
            chk_beat("bp.rel", exp_re(WIDTH'(k + 1) << 16), 1'b0, k == 7);
        end
        in_valid = 1'b0;
        tick();
        chk("bp.fcnt", frame_cnt, 16'd2);

        // Flush after 3 samples: 5 zero beats close the frame
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1;
            in_data  = 32'h0001_0000;
            tick();
            chk_beat("fl.data", exp_re(32'h0001_0000), k == 0, 1'b0);
        end
        in_valid = 1'b0;
        flush    = 1'b1;
        tick();
        flush = 1'b0;
        chk("fl.gap_valid", out_valid, 1'b0);
        for (int k = 3; k < 8; k++) begin
            chk("fl.pad_in_ready", in_ready, 1'b0);
            tick();
            chk_beat("fl.pad", 32'h0, 1'b0, k == 7);
        end
        chk("fl.post_in_ready", in_ready, 1'b1);
        tick();
        chk("fl.fcnt", frame_cnt, 16'd3);

        // Flush coincident with index 7 accept: no padding
        for (int k = 0; k < 8; k++) begin
            in_valid = 1'b1;
            in_data  = WIDTH'(k + 8) << 16;
            flush    = (k == 7);
            tick();
            chk_beat("fl7", exp_re(WIDTH'(k + 8) << 16), k == 0, k == 7);
        end
        in_valid = 1'b0;
        flush    = 1'b0;
        #1;
        chk("fl7.in_ready", in_ready, 1'b1);
        tick();
        chk("fl7.no_pad", out_valid, 1'b0);
        chk("fl7.fcnt",   frame_cnt, 16'd4);

        // Reset mid-frame after 4 samples
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1;
            in_data  = WIDTH'(k + 20) << 16;
            tick();
            chk_beat("mr", exp_re(WIDTH'(k + 20) << 16), k == 0, 1'b0);
        end
        rst_n = 1'b0;
        #1;
        chk("mr.valid", out_valid, 1'b0);
        chk("mr.re",    out_re,    32'h0);
        chk("mr.first", out_first, 1'b0);
        chk("mr.last",  out_last,  1'b0);
        chk("mr.fcnt",  frame_cnt, 16'h0);
        rst_n    = 1'b1;
        in_data  = 32'h0007_0000;
        #1;
        chk("mr.in_ready", in_ready, 1'b1);
        tick();
        chk_beat("mr.restart", exp_re(32'h0007_0000), 1'b1, 1'b0);

        // Scaling boundary values (unchanged when scaling is off)
        in_data = 32'h0008_0000;
        tick();
`ifdef FEEDER_SCALE_EN
        chk("sc.pos", out_re, 32'h0001_0000);
`else
        chk("sc.pos", out_re, 32'h0008_0000);
`endif
        in_data = 32'hFFF8_0000;
        tick();
`ifdef FEEDER_SCALE_EN
        chk("sc.neg", out_re, 32'hFFFF_0000);
`else
        chk("sc.neg", out_re, 32'hFFF8_0000);
`endif
        chk("sc.first", out_first, 1'b0);
        in_valid = 1'b0;
        tick();
        chk("end.valid", out_valid, 1'b0);
        chk("end.fcnt",  frame_cnt, 16'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
